// File: rtl/data_mem_ctrl.sv
// Clocked, handshaked data memory: byte/half/word accesses with per-byte lanes,
// load extension, fixed access latency and error flagging for bad accesses.
module data_mem_ctrl #(
   parameter int DEPTH  = 256,
   parameter int LAT    = 2,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              we_reg, sext_reg;
   logic [1:0]        size_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       rdata_reg;
   logic              err_reg;

   logic              accept, access;
   logic [IDX_W-1:0]  idx_in, idx_reg;
   logic [31:0]       ram_q;
   logic [3:0]        lane_en;
   logic [31:0]       lane_data;
   logic              range_err, acc_err;
   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;
   logic [31:0]       load_val;

   assign accept = req && (state_reg != BUSY);
   assign access = (state_reg == BUSY) && (cnt_reg == '0);
   assign busy   = (state_reg == BUSY);
   assign ready  = (state_reg == DONE);
   assign rdata  = rdata_reg;
   assign err    = err_reg;
   assign idx_in  = addr[2 +: IDX_W];
   assign idx_reg = addr_reg[2 +: IDX_W];

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (req) begin
               state_next = BUSY;
               cnt_next   = CNT_W'(LAT - 1);
            end else begin
               state_next = IDLE;
            end
         end
         BUSY: begin
            if (cnt_reg == '0) state_next = DONE;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   // Any address bit above the word index means the access is past the array.
   generate
      if (ADDR_W > IDX_W + 2) begin : g_range
         assign range_err = |addr_reg[ADDR_W-1:IDX_W+2];
      end else begin : g_norange
         assign range_err = 1'b0;
      end
   endgenerate

   always_comb begin
      acc_err = 1'b0;
      case (size_reg)
         2'b00:   acc_err = 1'b0;
         2'b01:   acc_err = addr_reg[0];
         2'b10:   acc_err = |addr_reg[1:0];
         default: acc_err = 1'b1;
      endcase
      acc_err = acc_err | range_err;
   end

   // Store data is replicated across lanes so each lane only needs its enable.
   always_comb begin
      lane_en   = 4'b0000;
      lane_data = wdata_reg;
      case (size_reg)
         2'b00: begin
            lane_en   = 4'b0001 << addr_reg[1:0];
            lane_data = {4{wdata_reg[7:0]}};
         end
         2'b01: begin
            lane_en   = addr_reg[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_reg[15:0]}};
         end
         2'b10:   lane_en = 4'b1111;
         default: lane_en = 4'b0000;
      endcase
   end

   // Read is launched at acceptance; only this access can write before completion.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] q_reg;
         always_ff @(posedge clk) begin
            if (accept)
               q_reg <= mem[idx_in];
            if (access && !rst && we_reg && !acc_err && lane_en[gi])
               mem[idx_reg] <= lane_data[8*gi +: 8];
         end
         assign ram_q[8*gi +: 8] = q_reg;
      end
   endgenerate

   always_comb begin
      sel_byte = ram_q[{addr_reg[1:0], 3'b000} +: 8];
      sel_half = addr_reg[1] ? ram_q[31:16] : ram_q[15:0];
      load_val = '0;
      case (size_reg)
         2'b00:   load_val = {{24{sext_reg & sel_byte[7]}}, sel_byte};
         2'b01:   load_val = {{16{sext_reg & sel_half[15]}}, sel_half};
         2'b10:   load_val = ram_q;
         default: load_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
         we_reg    <= 1'b0;
         sext_reg  <= 1'b0;
         size_reg  <= 2'b00;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            we_reg    <= we;
            sext_reg  <= sext;
            size_reg  <= size;
            addr_reg  <= addr;
            wdata_reg <= wdata;
         end
         if (access) begin
            err_reg   <= acc_err;
            rdata_reg <= (acc_err || we_reg) ? 32'h0 : load_val;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: driver pushes expected completions into a
// scoreboard queue, an independent monitor pops and compares on each ready pulse.
module tb_data_mem_ctrl;

   localparam int DEPTH  = 256;
   localparam int LAT    = 2;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              req;
   logic              we;
   logic [1:0]        size;
   logic              sext;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ready;
   logic              busy;
   logic              err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   op_id  = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH(DEPTH), .LAT(LAT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] er, input logic ee);
      exp_t e;
      e.rdata = er;
      e.err   = ee;
      e.id    = op_id;
      op_id++;
      sb.push_back(e);
   endtask

   // Monitor: every completion pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && ready) begin
         if (sb.size() == 0) begin
            check("unexpected_ready", {31'b0, ready}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("op%0d_rdata", e.id), rdata, e.rdata);
            check($sformatf("op%0d_err", e.id), {31'b0, err}, {31'b0, e.err});
            $display("op %0d: rdata=%h err=%b (expected %h/%b)", e.id, rdata, err, e.rdata, e.err);
         end
      end
   end

   // One isolated access; also measures busy length and completion latency.
   task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
      int nb;
      logic got;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
      push_exp(er, ee);
      @(posedge clk);
      #1 req = 1'b0;
      nb  = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (ready) got = 1'b1;
         else if (busy) nb++;
      end
      check("ready_seen", {31'b0, got}, 32'h1);
      check("busy_cycles", nb, LAT);
   endtask

   int bw  [4] = '{1, 0, 1, 0};
   int bsz [4] = '{2, 2, 0, 2};
   logic [31:0] bwd  [4] = '{32'h11112222, 32'h0, 32'h00000077, 32'h0};
   logic [31:0] bexp [4] = '{32'h0, 32'h11112222, 32'h0, 32'h11112277};

   initial begin
      int n;
      int last;
      rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_ready", {31'b0, ready}, 32'h0);
         check("idle_busy", {31'b0, busy}, 32'h0);
         check("idle_err", {31'b0, err}, 32'h0);
         check("idle_rdata", rdata, 32'h0);
      end

      do_op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
      do_op(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
      do_op(1, 2'b00, 0, 32'h11, 32'h00000055, 32'h0, 0);
      do_op(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0);
      do_op(0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
      do_op(0, 2'b00, 0, 32'h13, 32'h0, 32'h000000DE, 0);
      do_op(0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
      do_op(0, 2'b01, 0, 32'h10, 32'h0, 32'h000055EF, 0);
      do_op(0, 2'b00, 1, 32'h10, 32'h0, 32'hFFFFFFEF, 0);

      // Faulting accesses: flagged, no write, zero data.
      do_op(1, 2'b01, 0, 32'h11, 32'h0000AAAA, 32'h0, 1);
      do_op(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0);
      do_op(0, 2'b10, 0, 32'h402, 32'h0, 32'h0, 1);
      do_op(0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1);
      do_op(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
      do_op(0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1);
      do_op(1, 2'b10, 0, 32'h3FC, 32'hCAFEF00D, 32'h0, 0);
      do_op(0, 2'b10, 0, 32'h3FC, 32'h0, 32'hCAFEF00D, 0);
      do_op(1, 2'b01, 0, 32'h12, 32'h0000A1B2, 32'h0, 0);
      do_op(0, 2'b10, 0, 32'h10, 32'h0, 32'hA1B255EF, 0);

      // req held high: new op presented only when the DUT can accept; junk otherwise.
      n = 0;
      last = -1;
      @(negedge clk);
      req = 1'b1;
      for (int t = 0; t < 40 && n < 4; t++) begin
         if (t > 0) @(negedge clk);
         if (!busy) begin
            we = bw[n][0]; size = bsz[n][1:0]; sext = 1'b0; addr = 32'h30; wdata = bwd[n];
            push_exp(bexp[n], 1'b0);
            if (last >= 0) check("b2b_interval", t - last, LAT + 1);
            last = t;
            n++;
         end else begin
            we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hBADBAD00;
         end
      end
      check("b2b_accepted", n, 4);
      @(posedge clk);
      #1 req = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("b2b_drained", sb.size(), 0);

      // Reset one cycle after acceptance aborts the store.
      do_op(1, 2'b10, 0, 32'h20, 32'h0BADCAFE, 32'h0, 0);
      do_op(0, 2'b10, 0, 32'h20, 32'h0, 32'h0BADCAFE, 0);
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      rst = 1'b1; req = 1'b1;
      @(negedge clk);
      rst = 1'b0; req = 1'b0;
      check("abort_busy", {31'b0, busy}, 32'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_ready", {31'b0, ready}, 32'h0);
      end
      do_op(0, 2'b10, 0, 32'h20, 32'h0, 32'h0BADCAFE, 0);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
